// File: rtl/dmem_axil_bridge_pkg.sv
// rtl/dmem_axil_bridge_pkg.sv - state encoding and AXI response codes for the MEM-stage AXI4-Lite bridge
package dmem_axil_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/dmem_axil_bridge.sv
// rtl/dmem_axil_bridge.sv - MEM-stage load/store to AXI4-Lite master adapter with pipeline stall
module dmem_axil_bridge
  import dmem_axil_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    mem_r,
  input  logic                    mem_w,
  input  logic [DATA_WIDTH/8-1:0] mem_w_strb,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_w_data,
  output logic [DATA_WIDTH-1:0]   mem_r_data,
  output logic                    stall,
  output logic                    bus_err,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_WIDTH-1:0]   wstrb_q;
  logic                    aw_done;
  logic                    w_done;
  logic                    aw_hs;
  logic                    w_hs;
  logic                    aw_fin;
  logic                    w_fin;
  logic                    resp_err;

  // Valids are decoded from registered state only, so reset drops them at once.
  assign m_awvalid = (state == ST_WADDR) && !aw_done;
  assign m_wvalid  = (state == ST_WADDR) && !w_done;
  assign m_bready  = (state == ST_WRESP);
  assign m_arvalid = (state == ST_RADDR);
  assign m_rready  = (state == ST_RDATA);

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = wstrb_q;

  assign aw_hs  = m_awvalid && m_awready;
  assign w_hs   = m_wvalid && m_wready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  assign stall = (mem_r || mem_w) && (state != ST_DONE);

  assign resp_err = ((state == ST_WRESP) && m_bvalid && (m_bresp != RESP_OKAY)) ||
                    ((state == ST_RDATA) && m_rvalid && (m_rresp != RESP_OKAY));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (mem_w) begin
          state_next = ST_WADDR;
        end else if (mem_r) begin
          state_next = ST_RADDR;
        end
      end
      ST_WADDR: if (aw_fin && w_fin) state_next = ST_WRESP;
      ST_WRESP: if (m_bvalid) state_next = ST_DONE;
      ST_RADDR: if (m_arready) state_next = ST_RDATA;
      ST_RDATA: if (m_rvalid) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A simultaneous load request is dropped when a store is present.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state == ST_IDLE) begin
      if (mem_w) begin
        addr_q  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
        wdata_q <= mem_w_data;
        wstrb_q <= mem_w_strb;
      end else if (mem_r) begin
        addr_q  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
      end
    end
  end

  // Per-channel done flags clear on the cycle the write leaves WADDR.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      aw_done <= (state == ST_WADDR) && !(aw_fin && w_fin) && aw_fin;
      w_done  <= (state == ST_WADDR) && !(aw_fin && w_fin) && w_fin;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      mem_r_data <= '0;
      bus_err    <= 1'b0;
    end else begin
      bus_err <= resp_err;
      if ((state == ST_RDATA) && m_rvalid) begin
        mem_r_data <= m_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// tb/tb_dmem_axil_bridge.sv - directed and randomized bench for dmem_axil_bridge
module tb_dmem_axil_bridge;
  import dmem_axil_bridge_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        mem_r, mem_w;
  logic [3:0]  mem_w_strb;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;
  logic        stall, bus_err;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_rdata = '0;

  dmem_axil_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .aclk(aclk), .areset(areset),
    .mem_r(mem_r), .mem_w(mem_w), .mem_w_strb(mem_w_strb), .mem_addr(mem_addr),
    .mem_w_data(mem_w_data), .mem_r_data(mem_r_data), .stall(stall), .bus_err(bus_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic slave_quiet();
    m_awready = 0; m_wready = 0; m_arready = 0;
    m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
  endtask

  // One memory instruction against a slave with the given per-channel wait cycles.
  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic do_txn(input logic is_w, input logic is_r, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input int aw_d, input int w_d, input int b_d, input int ar_d,
                        input int r_d, input logic [31:0] rd, input logic [1:0] resp);
    int cyc = 0, stall_n = 0, err_n = 0, viol = 0, first_v = -1;
    int aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    int aw_wait = 0, w_wait = 0, ar_wait = 0, wr_acc_cyc = -1, ar_acc_cyc = -1;
    bit aw_acc = 0, w_acc = 0, ar_acc = 0, b_given = 0, r_given = 0, done = 0;
    bit aw_pend = 0, w_pend = 0, ar_pend = 0, err_done = 0;
    logic [31:0] got_awaddr = '0, got_wdata = '0, got_araddr = '0, rdata_done = '0;
    logic [3:0]  got_wstrb = '0;
    bit is_write = is_w;
    bit is_read = is_r && !is_w;
    int exp_stall = is_write ? 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d : 3 + ar_d + r_d;

    mem_w = is_w; mem_r = is_r; mem_addr = addr; mem_w_data = wd; mem_w_strb = strb;
    while (!done && cyc < 300) begin
      m_awready = m_awvalid && (aw_wait >= aw_d);
      m_wready  = m_wvalid && (w_wait >= w_d);
      m_arready = m_arvalid && (ar_wait >= ar_d);
      m_bvalid  = aw_acc && w_acc && !b_given && (cyc > wr_acc_cyc + b_d);
      m_rvalid  = ar_acc && !r_given && (cyc > ar_acc_cyc + r_d);
      m_bresp   = m_bvalid ? resp : 2'b00;
      m_rresp   = m_rvalid ? resp : 2'b00;
      m_rdata   = m_rvalid ? rd : ~rd;
      @(negedge aclk);
      if (!stall) begin
        done = 1; err_done = bus_err; rdata_done = mem_r_data;
      end else begin
        stall_n++;
        if (bus_err) err_n++;
      end
      if (first_v < 0 && (m_awvalid || m_wvalid || m_arvalid)) first_v = cyc;
      if ((aw_pend && !m_awvalid) || (w_pend && !m_wvalid) || (ar_pend && !m_arvalid)) viol++;
      aw_pend = m_awvalid && !m_awready;
      w_pend  = m_wvalid && !m_wready;
      ar_pend = m_arvalid && !m_arready;
      if (m_awvalid && m_awready) begin aw_n++; aw_acc = 1; got_awaddr = m_awaddr; end
      else if (m_awvalid) aw_wait++;
      if (m_wvalid && m_wready) begin w_n++; w_acc = 1; got_wdata = m_wdata; got_wstrb = m_wstrb; end
      else if (m_wvalid) w_wait++;
      if (m_arvalid && m_arready) begin ar_n++; ar_acc = 1; got_araddr = m_araddr; end
      else if (m_arvalid) ar_wait++;
      if (m_bvalid && m_bready) begin b_n++; b_given = 1; end
      if (m_rvalid && m_rready) begin r_n++; r_given = 1; end
      if (aw_acc && w_acc && wr_acc_cyc < 0) wr_acc_cyc = cyc;
      if (ar_acc && ar_acc_cyc < 0) ar_acc_cyc = cyc;
      @(posedge aclk); #1;
      cyc++;
    end
    slave_quiet();
    if (is_read) exp_rdata = rd;

    check("txn_timeout", done, 1);
    check("stall_cycles", stall_n, exp_stall);
    check("first_valid_cycle", first_v, 1);
    check("bus_err_before_done", err_n, 0);
    check("bus_err_in_done", err_done, resp != RESP_OKAY);
    check("aw_count", aw_n, is_write);
    check("w_count", w_n, is_write);
    check("b_count", b_n, is_write);
    check("ar_count", ar_n, is_read);
    check("r_count", r_n, is_read);
    check("valid_dropped", viol, 0);
    check("mem_r_data_done", rdata_done, exp_rdata);
    if (is_write) begin
      check("awaddr", got_awaddr, {addr[31:2], 2'b00});
      check("wdata", got_wdata, wd);
      check("wstrb", got_wstrb, strb);
    end
    if (is_read) check("araddr", got_araddr, {addr[31:2], 2'b00});
  endtask

  task automatic idle_cycles(input int n);
    mem_r = 0; mem_w = 0;
    slave_quiet();
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      check("idle_stall", stall, 0);
      check("idle_bus", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, bus_err}, 6'b0);
      check("idle_rdata_held", mem_r_data, exp_rdata);
      @(posedge aclk); #1;
    end
  endtask

  initial begin
    int k;
    logic [1:0] rsp;
    areset = 1; mem_r = 1; mem_w = 0; mem_addr = 32'h40; mem_w_data = 0; mem_w_strb = 0;
    slave_quiet();
    repeat (2) @(negedge aclk);
    check("rst_outputs", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, bus_err}, 6'b0);
    check("rst_rdata", mem_r_data, 32'h0);
    check("rst_stall_eq", stall, 1);
    @(posedge aclk); #1;
    mem_r = 0;
    #1;
    check("rst_stall_idle", stall, 0);
    @(posedge aclk); #1;
    areset = 0;
    idle_cycles(2);

    do_txn(1, 0, 32'h0000_1006, 32'hA5A5_1234, 4'b1100, 0, 0, 0, 0, 0, 0, RESP_OKAY);
    idle_cycles(1);
    do_txn(0, 1, 32'h0000_2000, 0, 0, 0, 0, 0, 0, 5, 32'hCAFE_F00D, RESP_OKAY);
    idle_cycles(3);
    do_txn(1, 0, 32'h0000_3008, 32'h1122_3344, 4'b1111, 2, 0, 0, 0, 0, 0, RESP_OKAY);
    do_txn(0, 1, 32'h0000_400C, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0_0001, RESP_SLVERR);
    idle_cycles(1);
    do_txn(1, 1, 32'h0000_5001, 32'h5555_AAAA, 4'b0011, 0, 1, 2, 0, 0, 0, RESP_DECERR);
    do_txn(0, 1, 32'h0000_6003, 0, 0, 0, 0, 0, 2, 0, 32'h0BAD_CAFE, RESP_OKAY);
    idle_cycles(1);

    // Reset while waiting on the R channel.
    mem_r = 1; mem_w = 0; mem_addr = 32'h0000_7000; m_arready = 1;
    k = 0;
    while (!m_rready && k < 10) begin
      @(posedge aclk); #1;
      k++;
    end
    check("reach_rdata", m_rready, 1);
    #2;
    areset = 1;
    #1;
    exp_rdata = '0;
    check("rst_mid_rready", m_rready, 0);
    check("rst_mid_arvalid", m_arvalid, 0);
    check("rst_mid_rdata", mem_r_data, exp_rdata);
    check("rst_mid_stall", stall, 1);
    m_arready = 0;
    @(posedge aclk); #1;
    areset = 0;
    do_txn(0, 1, 32'h0000_7004, 0, 0, 0, 0, 0, 0, 0, 32'h7777_0004, RESP_OKAY);

    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 2);
      rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : RESP_OKAY;
      do_txn(k != 1, k != 0, $urandom, $urandom, 4'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom, rsp);
      idle_cycles($urandom_range(0, 2));
    end
    idle_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
